// File: rtl/novaedge_mux_pkg.sv
// Shared definitions for the NovaEdge32 request-stream multiplexer slice.
package novaedge_mux_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mux_mode_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester after ptr,
// wrapping at N_CH. Returns a one-hot grant plus its index.
module rr_arbiter #(
    parameter int  N_CH = 4,
    localparam int CH_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [CH_W-1:0] ptr,
    output logic [N_CH-1:0] grant,
    output logic [CH_W-1:0] grant_idx
);

    always_comb begin
        logic            found;
        logic [CH_W-1:0] idx;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        // Offset N_CH wraps back to ptr itself, so it is searched last.
        for (int off = 1; off <= N_CH; off++) begin
            idx = CH_W'((int'(ptr) + off) % N_CH);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// Registered N-channel valid/ready stream mux with fixed-select or round-robin
// arbitration. Define STREAM_MUX_PKT_LOCK_EN to hold the grant for whole packets.
module stream_mux_rr
    import novaedge_mux_pkg::*;
#(
    parameter int  N_CH  = 4,
    parameter int  WIDTH = 32,
    localparam int CH_W  = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mode,
    input  logic [CH_W-1:0]       sel,
    input  logic [N_CH-1:0]       in_valid,
    input  logic [N_CH*WIDTH-1:0] in_data,
    input  logic [N_CH-1:0]       in_last,
    output logic [N_CH-1:0]       in_ready,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_last,
    output logic [CH_W-1:0]       out_chan,
    input  logic                  out_ready
);

    mux_mode_t        mode_e;
    logic [N_CH-1:0]  rr_grant;
    logic [CH_W-1:0]  rr_idx;
    logic [CH_W-1:0]  rr_ptr;
    logic [N_CH-1:0]  grant;
    logic [CH_W-1:0]  grant_idx;
    logic             can_load;
    logic             xfer;
    logic [WIDTH-1:0] data_p0;
    logic             last_p0;
    logic             vld_p1;
    logic [WIDTH-1:0] data_p1;
    logic             last_p1;
    logic [CH_W-1:0]  chan_p1;
`ifdef STREAM_MUX_PKT_LOCK_EN
    logic             lock_act;
    logic [CH_W-1:0]  lock_ch;
`endif

    assign mode_e = mux_mode_t'(mode);

    rr_arbiter #(.N_CH(N_CH)) u_arb (
        .req       (in_valid),
        .ptr       (rr_ptr),
        .grant     (rr_grant),
        .grant_idx (rr_idx)
    );

    always_comb begin
        grant     = '0;
        grant_idx = '0;
`ifdef STREAM_MUX_PKT_LOCK_EN
        if (lock_act) begin
            grant_idx      = lock_ch;
            grant[lock_ch] = in_valid[lock_ch];
        end else
`endif
        if (mode_e == MODE_RR) begin
            grant     = rr_grant;
            grant_idx = rr_idx;
        end else if (int'(sel) < N_CH) begin
            if (in_valid[sel]) begin
                grant[sel] = 1'b1;
                grant_idx  = sel;
            end
        end
    end

    assign can_load = !vld_p1 || out_ready;
    assign in_ready = grant & {N_CH{can_load}};
    assign xfer     = |(in_valid & in_ready);

    // p0: select the granted channel's beat
    always_comb begin
        data_p0 = '0;
        last_p0 = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (grant[i]) begin
                data_p0 = in_data[i*WIDTH +: WIDTH];
                last_p0 = in_last[i];
            end
        end
    end

    // p1: output register, plus arbitration state advanced on each transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1   <= 1'b0;
            data_p1  <= '0;
            last_p1  <= 1'b0;
            chan_p1  <= '0;
            rr_ptr   <= CH_W'(N_CH - 1);
`ifdef STREAM_MUX_PKT_LOCK_EN
            lock_act <= 1'b0;
            lock_ch  <= '0;
`endif
        end else begin
            if (can_load) begin
                vld_p1 <= xfer;
                if (xfer) begin
                    data_p1 <= data_p0;
                    last_p1 <= last_p0;
                    chan_p1 <= grant_idx;
                end
            end
`ifdef STREAM_MUX_PKT_LOCK_EN
            if (xfer) begin
                lock_act <= !last_p0;
                lock_ch  <= grant_idx;
                if (last_p0) begin
                    rr_ptr <= grant_idx;
                end
            end
`else
            if (xfer) begin
                rr_ptr <= grant_idx;
            end
`endif
        end
    end

    assign out_valid = vld_p1;
    assign out_data  = data_p1;
    assign out_last  = last_p1;
    assign out_chan  = chan_p1;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr with a per-cycle reference model and
// hand-computed spot checks.
module tb_stream_mux_rr;

    localparam int N = 4;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           mode;
    logic [1:0]     sel;
    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_last;
    logic [N-1:0]   in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic           out_last;
    logic [1:0]     out_chan;
    logic           out_ready;

    logic           mode3;
    logic [1:0]     sel3;
    logic [2:0]     in_valid3;
    logic [23:0]    in_data3;
    logic [2:0]     in_last3;
    logic [2:0]     in_ready3;
    logic           out_valid3;
    logic [7:0]     out_data3;
    logic           out_last3;
    logic [1:0]     out_chan3;
    logic           out_ready3;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    stream_mux_rr #(.N_CH(N), .WIDTH(W)) u_dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_last(out_last), .out_chan(out_chan), .out_ready(out_ready)
    );

    stream_mux_rr #(.N_CH(3), .WIDTH(8)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .mode(mode3), .sel(sel3),
        .in_valid(in_valid3), .in_data(in_data3), .in_last(in_last3),
        .in_ready(in_ready3), .out_valid(out_valid3), .out_data(out_data3),
        .out_last(out_last3), .out_chan(out_chan3), .out_ready(out_ready3)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the beat held downstream and the arbitration history.
    bit           m_vld = 1'b0;
    logic [W-1:0] m_data = '0;
    bit           m_last = 1'b0;
    int           m_chan = 0;
    int           m_ptr = N - 1;
    bit           m_lock = 1'b0;
    int           m_lock_ch = 0;

    function automatic int pick();
        if (m_lock) return in_valid[m_lock_ch] ? m_lock_ch : -1;
        if (mode) begin
            for (int k = 1; k <= N; k++) begin
                if (in_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
            end
            return -1;
        end
        if (int'(sel) < N && in_valid[sel]) return int'(sel);
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        int g;
        g = pick();
        if (g >= 0 && (!m_vld || out_ready)) return N'(1) << g;
        return '0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int g;
        if (!rst_n) begin
            m_vld = 1'b0; m_data = '0; m_last = 1'b0; m_chan = 0;
            m_ptr = N - 1; m_lock = 1'b0; m_lock_ch = 0;
        end else if (!m_vld || out_ready) begin
            g = pick();
            m_vld = (g >= 0);
            if (g >= 0) begin
                m_data = in_data[g*W +: W];
                m_last = in_last[g];
                m_chan = g;
`ifdef STREAM_MUX_PKT_LOCK_EN
                if (in_last[g]) begin
                    m_lock = 1'b0;
                    m_ptr = g;
                end else begin
                    m_lock = 1'b1;
                    m_lock_ch = g;
                end
`else
                m_ptr = g;
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            chk("model_in_ready", in_ready, exp_ready());
            chk("model_out_valid", out_valid, m_vld);
            if (m_vld) begin
                chk("model_out_data", out_data, m_data);
                chk("model_out_last", out_last, m_last);
                chk("model_out_chan", out_chan, m_chan);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int exp_rr[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
`ifdef STREAM_MUX_PKT_LOCK_EN
    int exp_pkt[4] = '{1, 1, 1, 2};
`else
    int exp_pkt[4] = '{1, 2, 3, 0};
`endif

    initial begin
        mode = 1'b0; sel = 2'd0; in_valid = '0; in_last = '1; out_ready = 1'b1;
        in_data = {32'h3333_0003, 32'h2222_0002, 32'h1111_0001, 32'h0A0A_0000};
        mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111; in_last3 = 3'b111;
        in_data3 = {8'hC2, 8'hC1, 8'hC0}; out_ready3 = 1'b1;

        #12;
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_out_data", out_data, 32'h0);
        chk("reset_out_last", out_last, 1'b0);
        chk("reset_out_chan", out_chan, 2'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk_en = 1'b1;

        // Round robin from reset: ch0 first, then one beat per cycle in order.
        mode = 1'b1;
        in_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("rr_out_valid", out_valid, 1'b1);
            chk("rr_out_chan", out_chan, exp_rr[i]);
        end

        // Fixed select of channel 2.
        mode = 1'b0;
        sel = 2'd2;
        in_data[2*W +: W] = 32'hA5A5_0002;
        #1;
        chk("fixed_in_ready", in_ready, 4'b0100);
        step();
        chk("fixed_out_data", out_data, 32'hA5A5_0002);
        chk("fixed_out_chan", out_chan, 2'd2);

        // Backpressure: held beat stays put, nothing accepted.
        out_ready = 1'b0;
        in_data[2*W +: W] = 32'hBBBB_0002;
        #1;
        chk("bp_in_ready", in_ready, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_out_data", out_data, 32'hA5A5_0002);
            chk("bp_out_valid", out_valid, 1'b1);
            chk("bp_in_ready", in_ready, 4'b0000);
        end
        out_ready = 1'b1;
        in_data[2*W +: W] = 32'hC0DE_0002;
        #1;
        chk("bp_release_in_ready", in_ready, 4'b0100);
        step();
        chk("bp_release_out_data", out_data, 32'hC0DE_0002);

        // Park the round-robin pointer on ch0, then send a 3-beat packet on ch1.
        sel = 2'd0;
        in_valid = 4'b0001;
        step();
        chk("park_out_chan", out_chan, 2'd0);
        mode = 1'b1;
        in_valid = 4'b1111;
        in_last = 4'b1101;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) in_last = 4'b1111;
            step();
            chk("pkt_out_chan", out_chan, exp_pkt[i]);
        end

        // Asynchronous reset while a beat is held.
        mode = 1'b0;
        sel = 2'd3;
        step();
        chk("prerst_out_chan", out_chan, 2'd3);
        chk("prerst_out_valid", out_valid, 1'b1);
        chk_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", out_valid, 1'b0);
        chk("async_rst_out_chan", out_chan, 2'd0);
        chk("async_rst_out_data", out_data, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk_en = 1'b1;
        mode = 1'b1;
        step();
        chk("post_rst_rr_chan", out_chan, 2'd0);

        // Out-of-range select on a 3-channel instance grants nothing.
        chk("oor_in_ready", in_ready3, 3'b000);
        step();
        chk("oor_out_valid", out_valid3, 1'b0);
        step();
        chk("oor_out_valid", out_valid3, 1'b0);
        sel3 = 2'd2;
        #1;
        chk("n3_in_ready", in_ready3, 3'b100);
        step();
        chk("n3_out_data", out_data3, 8'hC2);
        chk("n3_out_chan", out_chan3, 2'd2);

        in_valid = '0;
        step();
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
